// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM encoding and PC constants.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StBubble  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_RESET    = 32'hFFFF_FFFC;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_ctrl_redirect_hold.sv
// Holds a branch/jump target that arrived while fetch was stalled until the PC can take it.
module redirect_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    input  logic        i_stall,
    output logic        o_pend_valid,
    output logic [31:0] o_pend_target
);

    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (i_redirect_valid && i_stall) begin
            // Latest redirect wins while the PC is held.
            r_pend_valid  <= 1'b1;
            r_pend_target <= i_redirect_target;
        end else if (!i_stall) begin
            r_pend_valid  <= 1'b0;
        end
    end

    assign o_pend_valid  = r_pend_valid;
    assign o_pend_target = r_pend_target;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch control: next-PC selection, imem wait stalls, load-use bubbles, redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        imem_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        load_use_hazard,
    output logic [31:0] npc,
    output logic        stall,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        fetch_timeout
);

    localparam logic [3:0]  BubInit = 4'(LOAD_USE_BUBBLES - 1);
    localparam logic [15:0] WaitMax = 16'(MEM_TIMEOUT);

    fetch_state_e r_state;
    logic [3:0]   r_bub_cnt;
    logic [15:0]  r_wait_cnt;
    logic         r_timeout;

    logic         w_stall;
    logic         w_lu_flush;
    logic         w_pend_valid;
    logic [31:0]  w_pend_target;
    logic [31:0]  w_pc_inc;

    redirect_hold u_redirect_hold (
        .clk               (clk),
        .rst               (rst),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_stall           (w_stall),
        .o_pend_valid      (w_pend_valid),
        .o_pend_target     (w_pend_target)
    );

    assign w_pc_inc = pc + INSTR_BYTES;

    always_comb begin
        w_stall    = 1'b0;
        w_lu_flush = 1'b0;
        if (!rst) begin
            unique case (r_state)
                StRun: begin
                    if (!imem_ready) begin
                        w_stall = 1'b1;
                    end else if (load_use_hazard && !redirect_valid) begin
                        // Hazard behind a redirect is on the wrong path.
                        w_stall    = 1'b1;
                        w_lu_flush = 1'b1;
                    end
                end
                StMemWait: w_stall = !imem_ready;
                StBubble: begin
                    w_stall    = 1'b1;
                    w_lu_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (rst)                 npc = w_pc_inc;
        else if (w_pend_valid)   npc = w_pend_target;
        else if (redirect_valid) npc = redirect_target;
        else                     npc = w_pc_inc;
    end

    assign stall         = w_stall;
    assign flush_ifid    = redirect_valid & ~rst;
    assign flush_idex    = (redirect_valid | w_lu_flush) & ~rst;
    assign fetch_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_bub_cnt  <= 4'd0;
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (!imem_ready) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= 16'd1;
                        if (WaitMax == 16'd1) r_timeout <= 1'b1;
                    end else if (load_use_hazard && !redirect_valid) begin
                        r_bub_cnt <= BubInit;
                        if (BubInit != 4'd0) r_state <= StBubble;
                    end
                end
                StMemWait: begin
                    if (imem_ready) begin
                        r_state    <= StRun;
                        r_wait_cnt <= 16'd0;
                    end else if (r_wait_cnt != WaitMax) begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                        if (r_wait_cnt + 16'd1 == WaitMax) r_timeout <= 1'b1;
                    end
                end
                StBubble: begin
                    r_bub_cnt <= r_bub_cnt - 4'd1;
                    if (r_bub_cnt == 4'd1) r_state <= StRun;
                end
                default: r_state <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with LOAD_USE_BUBBLES=2, MEM_TIMEOUT=4.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        load_use_hazard;
    logic [31:0] npc;
    logic        stall;
    logic        flush_ifid;
    logic        flush_idex;
    logic        fetch_timeout;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(
        .LOAD_USE_BUBBLES (2),
        .MEM_TIMEOUT      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .imem_ready      (imem_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .load_use_hazard (load_use_hazard),
        .npc             (npc),
        .stall           (stall),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .fetch_timeout   (fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and let combinational outputs settle.
    task automatic drive(input logic [31:0] p, input logic rdy, input logic rv,
                         input logic [31:0] tgt, input logic luh);
        pc              = p;
        imem_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        load_use_hazard = luh;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_npc, input logic e_stall,
                             input logic e_fifid, input logic e_fidex);
        check_val({tag, ".npc"}, npc, e_npc);
        check_val({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
        check_val({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, e_fifid});
        check_val({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, e_fidex});
    endtask

    initial begin
        // Reset; a redirect during reset must not leak to outputs.
        rst = 1'b1;
        drive(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h300, 1'b1);
        check_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_val("rst.timeout", {31'd0, fetch_timeout}, 32'd0);
        rst = 1'b0;

        // Free run, PC wraps from FFFF_FFFC to 0.
        drive(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("run0", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("run1", 32'h4, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h4, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("run2", 32'h8, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h8, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("run3", 32'hC, 1'b0, 1'b0, 1'b0);
        tick();

        // Unstalled redirect.
        drive(32'h10, 1'b1, 1'b1, 32'h200, 1'b0);
        check_out("redir", 32'h200, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("redir_next", 32'h204, 1'b0, 1'b0, 1'b0);
        tick();

        // Imem wait of 3 cycles, redirect captured on the 2nd.
        drive(32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        check_out("mw1", 32'h24, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h20, 1'b0, 1'b1, 32'h80, 1'b0);
        check_out("mw2", 32'h80, 1'b1, 1'b1, 1'b1);
        tick();
        drive(32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        check_out("mw3", 32'h80, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("mw_rel", 32'h80, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("mw_after", 32'h84, 1'b0, 1'b0, 1'b0);
        check_val("mw.timeout", {31'd0, fetch_timeout}, 32'd0);
        tick();

        // Load-use hazard: two bubble cycles.
        drive(32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        check_out("lu1", 32'h44, 1'b1, 1'b0, 1'b1);
        tick();
        drive(32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        check_out("lu2", 32'h44, 1'b1, 1'b0, 1'b1);
        tick();
        drive(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("lu_end", 32'h44, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h44, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("lu_resume", 32'h48, 1'b0, 1'b0, 1'b0);
        tick();

        // Hazard coincident with redirect is ignored.
        drive(32'h48, 1'b1, 1'b1, 32'h100, 1'b1);
        check_out("lu_redir", 32'h100, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("lu_redir_next", 32'h104, 1'b0, 1'b0, 1'b0);
        tick();

        // Two redirects while stalled: latest wins.
        drive(32'h60, 1'b0, 1'b1, 32'h300, 1'b0);
        check_out("lw1", 32'h300, 1'b1, 1'b1, 1'b1);
        tick();
        drive(32'h60, 1'b0, 1'b1, 32'h400, 1'b0);
        check_out("lw2", 32'h300, 1'b1, 1'b1, 1'b1);
        tick();
        drive(32'h60, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("lw_rel", 32'h400, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h400, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("lw_after", 32'h404, 1'b0, 1'b0, 1'b0);
        tick();

        // Imem timeout after 4 wait cycles, sticky until reset.
        for (int i = 0; i < 4; i++) begin
            drive(32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
            check_val($sformatf("to_wait%0d.stall", i), {31'd0, stall}, 32'd1);
            check_val($sformatf("to_wait%0d.timeout", i), {31'd0, fetch_timeout}, 32'd0);
            tick();
        end
        check_val("to_set", {31'd0, fetch_timeout}, 32'd1);
        drive(32'h104, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("to_ready.stall", {31'd0, stall}, 32'd0);
        tick();
        drive(32'h108, 1'b1, 1'b0, 32'h0, 1'b0);
        check_val("to_sticky", {31'd0, fetch_timeout}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("to_rst_before_edge", {31'd0, fetch_timeout}, 32'd1);
        tick();
        check_val("to_rst_cleared", {31'd0, fetch_timeout}, 32'd0);
        rst = 1'b0;
        drive(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0);
        check_out("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
